// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential signed 32x32 multiplier / divider with HI/LO result registers.
// Multiply uses 32 shift-add steps and divide uses 32 restoring steps, one per cycle, on
// operand magnitudes. Sign correction is applied on the last step.
// Build option: define MULT_DIV_ZERO_FAST_EN to finish a divide-by-zero one cycle after it
// is accepted, instead of after the full 32-step run.
module mult_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    // Shared datapath: multiply keeps {partial product, multiplier};
    // divide keeps {partial remainder, dividend/quotient}.
    logic [63:0] acc_q;
    logic [31:0] mag_b_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic        b_zero_q;
    logic        busy_q;
    logic        done_q;
    logic        div_zero_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        last;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_nxt;
    logic [63:0] acc_nxt;
    logic [63:0] prod_signed;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;

    // Operand magnitudes, one iteration step of each algorithm, and sign-corrected results.
    always_comb begin
        accept    = start && ((state_q == StIdle) || (state_q == StDone));
        last      = (cnt_q == 5'd31);
        mag_a     = a[31] ? (~a + 32'd1) : a;
        mag_b     = b[31] ? (~b + 32'd1) : b;

        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
        mul_nxt   = {mul_sum, acc_q[31:1]};

        // Remainder is always below the divisor, so the shifted value fits in 33 bits
        // and bit 32 of the difference is a clean borrow.
        div_shift = acc_q[63:31];
        div_diff  = div_shift - {1'b0, mag_b_q};
        div_nxt   = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

        acc_nxt   = (state_q == StMult) ? mul_nxt : div_nxt;

        prod_signed = (neg_a_q ^ neg_b_q) ? (~acc_nxt + 64'd1) : acc_nxt;
        quo_signed  = (neg_a_q ^ neg_b_q) ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
        rem_signed  = neg_a_q ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];
    end

    // Control FSM, iteration datapath and registered status/result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            mag_b_q    <= 32'd0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            b_zero_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else if (accept) begin
            neg_a_q    <= a[31];
            neg_b_q    <= b[31];
            mag_b_q    <= mag_b;
            acc_q      <= {32'd0, mag_a};
            cnt_q      <= 5'd0;
            b_zero_q   <= (b == 32'd0);
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            if (!op) begin
                state_q <= StMult;
            end
`ifdef MULT_DIV_ZERO_FAST_EN
            else if (b == 32'd0) begin
                state_q    <= StDone;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                div_zero_q <= 1'b1;
            end
`endif
            else begin
                state_q <= StDiv;
            end
        end else begin
            case (state_q)
                StMult, StDiv: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + 5'd1;
                    if (last) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (state_q == StMult) begin
                            hi_q <= prod_signed[63:32];
                            lo_q <= prod_signed[31:0];
                        end else if (b_zero_q) begin
                            // Divide by zero: flag it and leave HI/LO untouched.
                            div_zero_q <= 1'b1;
                        end else begin
                            hi_q <= rem_signed;
                            lo_q <= quo_signed;
                        end
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    done_q     <= 1'b0;
                    div_zero_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed vectors with hand-computed results for mult_div_seq.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MULT_DIV_ZERO_FAST_EN
    localparam int DzLat = 1;
`else
    localparam int DzLat = 33;
`endif

    mult_div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle start; returns #1 after the accepting edge.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges counted with the accepting edge as 1; bounded so a stuck DUT still ends.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input string tag, input logic o, input logic [31:0] x,
                       input logic [31:0] y, input int lat, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic exp_dz);
        int n;
        issue(o, x, y);
        wait_done(1, n);
        check({tag, "_latency"}, n, lat);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_div_zero"}, div_zero, exp_dz);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_dz_one_cycle"}, div_zero, 1'b0);
    endtask

    initial begin
        int n;
        int pulses;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_dz", div_zero, 1'b0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("div_5_0", 1'b1, 32'd5, 32'd0, DzLat, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        run("mult_m5_m6", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 33, 32'd0, 32'h0000_001E, 1'b0);
        run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'd0,
            1'b0);

        // start during an operation is ignored.
        issue(1'b0, 32'd100, 32'd200);
        check("restart_busy", busy, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_still_busy", busy, 1'b1);
        check("restart_hilo_held", {hi, lo}, 64'h4000_0000_0000_0000);
        wait_done(11, n);
        check("restart_latency", n, 33);
        check("restart_hi", hi, 32'd0);
        check("restart_lo", lo, 32'h0000_4E20);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("restart_no_second_done", pulses, 0);

        // Reset in the middle of a divide.
        issue(1'b1, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postreset_hilo", {hi, lo}, 64'd0);
        check("postreset_done", done, 1'b0);
        run("mult_3_4", 1'b0, 32'd3, 32'd4, 33, 32'd0, 32'h0000_000C, 1'b0);

        // Back-to-back: start asserted in the DONE cycle.
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, n);
        check("b2b1_latency", n, 33);
        check("b2b1_lo", lo, 32'h8000_0000);
        check("b2b1_hi", hi, 32'd0);
        check("b2b1_dz", div_zero, 1'b0);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'h8000_0000;
        b     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b2_accepted_busy", busy, 1'b1);
        check("b2b2_accepted_done", done, 1'b0);
        wait_done(1, n);
        check("b2b2_latency", n, 33);
        check("b2b2_lo", lo, 32'h8000_0000);
        check("b2b2_hi", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  reset; asynchronous, active-low.
REQ-003 start  input  1  one-cycle operation request from the control unit.
REQ-004 op  input  1  operation select: 0 = MULT, 1 = DIV; same encoding as MultOrDiv.
REQ-005 a  input  32  signed operand (rs value from register A); sampled only when start is accepted.
REQ-006 b  input  32  signed operand (rt value from register B); sampled only when start is accepted.
REQ-007 busy  output  1  high while an iteration is in progress.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 div_zero  output  1  one-cycle divide-by-zero pulse, coincident with done; drives ErroDiv.
REQ-010 hi  output  32  HI result register.
REQ-011 lo  output  32  LO result register.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, MULT, DIV and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; on acceptance, a and b SHALL be latched as magnitudes with sign flags, the 5-bit counter cleared, and the next state set to MULT (op=0) or DIV (op=1).
REQ-014 start in MULT or DIV SHALL be ignored, with no effect on operands, counter or results.
REQ-015 MULT SHALL perform 32 shift-add iterations on the unsigned magnitudes, one per cycle, producing a 64-bit product.
REQ-016 DIV SHALL perform 32 restoring-division iterations on the unsigned magnitudes, one per cycle.
REQ-017 After the 32nd iteration (counter = 31), the FSM SHALL go to DONE, applying sign correction and loading hi and lo on that same edge.
REQ-018 MULT results: {hi,lo} = signed 64-bit product a*b.
REQ-019 DIV results: lo = quotient truncated toward zero, sign = sign(a) XOR sign(b); hi = remainder, sign = sign(a).
REQ-020 Division of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000 (wrap, no error).
REQ-021 done SHALL be high exactly during the DONE state, which lasts one cycle and goes to IDLE unless start is accepted.
REQ-022 Latency for non-error operations: done high in the cycle after the 33rd rising edge counted from the edge that accepted start.
REQ-023 busy SHALL be high only in MULT and DIV.
REQ-024 hi and lo SHALL hold their values between completions; they SHALL NOT change while busy.
REQ-025 When op=1 and b=0: div_zero SHALL pulse with done, and hi and lo SHALL remain unchanged.

Reset
REQ-026 reset low SHALL immediately force IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0 and lo=0, including in the middle of an operation.
REQ-027 No partial result SHALL reach hi or lo after reset is released; the first start after release begins a fresh operation.

Configuration
REQ-028 Macro MULT_DIV_ZERO_FAST_EN SHALL control divide-by-zero latency.
REQ-029 With MULT_DIV_ZERO_FAST_EN defined: a DIV with b=0 SHALL go directly from acceptance to DONE, with done and div_zero high in the cycle after the accepting edge, and busy never asserted.
REQ-030 Without MULT_DIV_ZERO_FAST_EN: a DIV with b=0 SHALL run the full 32 iterations, with the REQ-022 latency, and results discarded per REQ-025.

Verification
REQ-031 MULT a=7, b=0xFFFFFFFD (-3) -> done at 33-edge latency; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-033 DIV a=5, b=0, with the macro set and again without it -> div_zero=done=1 after 1 and 33 edges respectively; hi and lo keep their prior values.
REQ-034 Pulse start again 10 cycles into a MULT with different operands -> first result is unaffected; no second done follows.
REQ-035 Assert reset at iteration 15 of a DIV -> busy, done, hi and lo are all 0 immediately; start a fresh MULT 3*4 after release -> lo=0x0000000C, hi=0.
REQ-036 Assert start in the DONE cycle (back-to-back DIV 0x80000000 / 0xFFFFFFFF) -> accepted with no idle gap; lo=0x80000000, hi=0.
